// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-requester round-robin arbiter onto a single strobed IO bus
// One transaction in flight; a stalled bus is aborted after TIMEOUT wait cycles with ERR_DATA.
module io_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_ACK,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_ACK,
  output logic [31:0] M1_RDATA,
  output logic        ERR,
  output logic [31:0] IO_Address,
  output logic [31:0] IO_Write_Data,
  output logic        IO_Addr_Strobe,
  output logic        IO_Read_Strobe,
  output logic        IO_Write_Strobe,
  input  logic [31:0] IO_Read_Data,
  input  logic        IO_Ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

  state_t      state;
  logic        last;
  logic        gnt;
  logic        we_q;
  logic [8:0]  wait_cnt;

  logic        pick;
  logic        cnt_hit;
  logic        complete;
  logic        timed_out;
  logic [31:0] cap_data;

  always_comb begin
    pick      = (M0_REQ && M1_REQ) ? ~last : M1_REQ;
    cnt_hit   = (wait_cnt + 9'd1) == TIMEOUT_CNT;
    complete  = 1'b0;
    timed_out = 1'b0;
    if (state == ISSUE) begin
      complete = IO_Ready;
    end else if (state == WAIT) begin
      complete  = IO_Ready || cnt_hit;
      timed_out = !IO_Ready && cnt_hit;
    end
    cap_data = timed_out ? ERR_DATA : IO_Read_Data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      last            <= 1'b1;
      gnt             <= 1'b0;
      we_q            <= 1'b0;
      wait_cnt        <= '0;
      M0_ACK          <= 1'b0;
      M1_ACK          <= 1'b0;
      ERR             <= 1'b0;
      M0_RDATA        <= '0;
      M1_RDATA        <= '0;
      IO_Address      <= '0;
      IO_Write_Data   <= '0;
      IO_Addr_Strobe  <= 1'b0;
      IO_Read_Strobe  <= 1'b0;
      IO_Write_Strobe <= 1'b0;
    end else begin
      M0_ACK          <= 1'b0;
      M1_ACK          <= 1'b0;
      ERR             <= 1'b0;
      IO_Addr_Strobe  <= 1'b0;
      IO_Read_Strobe  <= 1'b0;
      IO_Write_Strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (M0_REQ || M1_REQ) begin
            gnt             <= pick;
            last            <= pick;
            we_q            <= pick ? M1_WE : M0_WE;
            IO_Address      <= pick ? M1_ADDR : M0_ADDR;
            IO_Write_Data   <= pick ? M1_WDATA : M0_WDATA;
            IO_Addr_Strobe  <= 1'b1;
            IO_Read_Strobe  <= pick ? !M1_WE : !M0_WE;
            IO_Write_Strobe <= pick ? M1_WE : M0_WE;
            wait_cnt        <= '0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (!complete) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 9'd1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Completion from ISSUE or WAIT: ACK/ERR/RDATA are registered so they appear in DONE.
      if (complete) begin
        state  <= DONE;
        M0_ACK <= !gnt;
        M1_ACK <= gnt;
        ERR    <= timed_out;
        if (!we_q && !gnt) M0_RDATA <= cap_data;
        if (!we_q && gnt)  M1_RDATA <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - randomized self-checking bench for io_bus_arbiter
// Reference model works per transaction: grant choice, completion cycle and returned data.
module tb_io_bus_arbiter;

  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        M0_REQ, M0_WE, M0_ACK;
  logic [31:0] M0_ADDR, M0_WDATA, M0_RDATA;
  logic        M1_REQ, M1_WE, M1_ACK;
  logic [31:0] M1_ADDR, M1_WDATA, M1_RDATA;
  logic        ERR;
  logic [31:0] IO_Address, IO_Write_Data, IO_Read_Data;
  logic        IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe, IO_Ready;

  io_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA),
    .ERR(ERR),
    .IO_Address(IO_Address), .IO_Write_Data(IO_Write_Data),
    .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
    .IO_Write_Strobe(IO_Write_Strobe),
    .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  bit          req [2];
  bit          we_m [2];
  logic [31:0] addr_m [2];
  logic [31:0] wdata_m [2];
  logic [31:0] exp_rd [2];
  int          last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_masters();
    M0_REQ = req[0]; M0_WE = we_m[0]; M0_ADDR = addr_m[0]; M0_WDATA = wdata_m[0];
    M1_REQ = req[1]; M1_WE = we_m[1]; M1_ADDR = addr_m[1]; M1_WDATA = wdata_m[1];
  endtask

  task automatic set_master(input int m, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    req[m] = 1'b1; we_m[m] = we; addr_m[m] = addr; wdata_m[m] = wdata;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack0"}, M0_ACK, 0);
    check({tag, "_ack1"}, M1_ACK, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_strobes"}, {IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe}, 0);
    check({tag, "_addr"}, IO_Address, 0);
    check({tag, "_wdata"}, IO_Write_Data, 0);
    check({tag, "_rdata0"}, M0_RDATA, 0);
    check({tag, "_rdata1"}, M1_RDATA, 0);
  endtask

  // Called just after the negedge of an IDLE cycle. d = cycles after the strobe cycle
  // at which IO_Ready is given (0 = during the strobe); d > TIMEOUT means never.
  task automatic run_txn(input int d, input logic [31:0] rd);
    int g;
    int ack_at;
    bit err;
    drive_masters();
    g      = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
    last   = g;
    err    = d > TIMEOUT;
    ack_at = 2 + (err ? TIMEOUT : d);
    for (int k = 1; k <= ack_at; k++) begin
      @(negedge CLK);
      check("addr_strobe", IO_Addr_Strobe, k == 1);
      check("read_strobe", IO_Read_Strobe, k == 1 && !we_m[g]);
      check("write_strobe", IO_Write_Strobe, k == 1 && we_m[g]);
      check("io_address", IO_Address, addr_m[g]);
      check("io_write_data", IO_Write_Data, wdata_m[g]);
      check("m0_ack", M0_ACK, k == ack_at && g == 0);
      check("m1_ack", M1_ACK, k == ack_at && g == 1);
      check("err", ERR, k == ack_at && err);
      if (k == ack_at) begin
        if (!we_m[g]) exp_rd[g] = err ? ERR_DATA : rd;
        check("m0_rdata", M0_RDATA, exp_rd[0]);
        check("m1_rdata", M1_RDATA, exp_rd[1]);
        req[g] = 1'b0;
        drive_masters();
        IO_Ready     = 1'($urandom_range(0, 1));
        IO_Read_Data = $urandom;
      end else begin
        IO_Ready     = (k == 1 + d);
        IO_Read_Data = (k == 1 + d) ? rd : $urandom;
      end
    end
    @(negedge CLK);
  endtask

  task automatic random_fill(input int m);
    set_master(m, 1'($urandom_range(0, 1)),
               {8'hC0 + 8'($urandom_range(0, 3)), 24'($urandom)}, $urandom);
  endtask

  task automatic random_txn();
    int sel;
    int d;
    for (int m = 0; m < 2; m++)
      if (!req[m] && $urandom_range(0, 1) == 1) random_fill(m);
    if (!req[0] && !req[1]) random_fill(int'($urandom_range(0, 1)));
    sel = int'($urandom_range(0, 9));
    if (sel < 7)       d = int'($urandom_range(0, 6));
    else if (sel == 7) d = int'($urandom_range(7, 40));
    else if (sel == 8) d = TIMEOUT;
    else               d = TIMEOUT + 1;
    run_txn(d, $urandom);
  endtask

  initial begin
    last = 1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; we_m[m] = 0; addr_m[m] = '0; wdata_m[m] = '0; exp_rd[m] = '0;
    end
    drive_masters();
    IO_Ready = 1'b0; IO_Read_Data = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RST = 1'b0;

    // Both requesting from reset: alternation starting with M0
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++) if (!req[m]) random_fill(m);
      run_txn(int'($urandom_range(0, 3)), $urandom);
    end
    if (req[0]) begin
      req[0] = 0; req[1] = 0;
    end
    req[1] = 0;
    drive_masters();

    set_master(0, 1'b0, 32'hC1000004, 32'h0);
    run_txn(1, 32'h12345678);
    set_master(0, 1'b0, 32'hC0000100, 32'h0);
    run_txn(0, 32'h0BADF00D);
    set_master(1, 1'b1, 32'hC2000000, 32'hA5A5A5A5);
    run_txn(TIMEOUT + 1, 32'h0);
    set_master(1, 1'b0, 32'hC3000008, 32'h0);
    run_txn(TIMEOUT, 32'h55AA55AA);

    // Reset while waiting on the bus
    set_master(0, 1'b0, 32'hC3000010, 32'h0);
    drive_masters();
    IO_Ready = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    req[0] = 0;
    drive_masters();
    @(negedge CLK);
    check_idle_outputs("mid_reset");
    RST = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; last = 1;
    set_master(0, 1'b0, 32'hC1000020, 32'h0);
    run_txn(2, 32'hCAFEF00D);

    for (int i = 0; i < 60; i++) random_txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
